// File: rtl/pkt_egress_arb_if.sv
// Packet egress arbiter bundle: per-port ingress byte streams plus the single egress stream.
// master = arbiter side, slave = upstream FIFOs / egress sink side.
interface pkt_egress_arb_if #(
  parameter int NUM_PORTS = 4,
  parameter int ACTION_W  = 64
);
  logic [NUM_PORTS-1:0]          in_valid;
  logic [8*NUM_PORTS-1:0]        in_data;
  logic [NUM_PORTS-1:0]          in_last;
  logic [ACTION_W*NUM_PORTS-1:0] in_action;
  logic [NUM_PORTS-1:0]          in_ready;
  logic                          out_valid;
  logic [7:0]                    out_data;
  logic                          out_last;
  logic                          out_ready;
  logic [ACTION_W-1:0]           out_action;
  logic [$clog2(NUM_PORTS)-1:0]  out_port;
  logic                          out_sop;
  logic                          err_timeout;

  modport master (
    input  in_valid, in_data, in_last, in_action, out_ready,
    output in_ready, out_valid, out_data, out_last, out_action, out_port, out_sop, err_timeout
  );

  modport slave (
    output in_valid, in_data, in_last, in_action, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_action, out_port, out_sop, err_timeout
  );
endinterface

// File: rtl/pkt_egress_arb.sv
// Round-robin packet egress arbiter: grants one upstream port per packet and muxes its bytes out.
// Optional stall watchdog enabled by defining PKT_EGRESS_ARB_WATCHDOG_EN.
module pkt_egress_arb #(
  parameter int NUM_PORTS = 4,
  parameter int ACTION_W  = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  pkt_egress_arb_if.master  bus
);
  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] last_grant;
  logic [PW-1:0] hi_sel, lo_sel, arb_sel;
  logic          hi_hit, lo_hit, arb_hit;
  logic          sop_pend;
  logic          grant_valid;
  logic          xfer;
  logic          wd_fire;

  // Lowest valid port above last_grant wins; otherwise lowest valid port at or below it (wrap).
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_sel = '0;
    lo_sel = '0;
    for (int unsigned j = NUM_PORTS; j > 0; j--) begin
      if (bus.in_valid[PW'(j-1)]) begin
        if ((j - 1) > 32'(last_grant)) begin
          hi_hit = 1'b1;
          hi_sel = PW'(j-1);
        end else begin
          lo_hit = 1'b1;
          lo_sel = PW'(j-1);
        end
      end
    end
    arb_hit = hi_hit | lo_hit;
    arb_sel = hi_hit ? hi_sel : lo_sel;
  end

  assign grant_valid = bus.in_valid[bus.out_port];
  assign xfer        = (state == XFER) && grant_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arb_hit) state_nxt = XFER;
      XFER: if ((xfer && bus.out_last) || wd_fire) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.out_sop   = 1'b0;
    if (state == XFER) begin
      bus.out_valid             = grant_valid;
      bus.out_data              = bus.in_data[8*bus.out_port +: 8];
      bus.out_last              = bus.in_last[bus.out_port];
      bus.in_ready[bus.out_port] = bus.out_ready;
      bus.out_sop               = sop_pend & grant_valid;
    end
  end

  // out_port doubles as the grant register; it only changes on a new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant     <= PW'(NUM_PORTS - 1);
      bus.out_port   <= '0;
      bus.out_action <= '0;
      sop_pend       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            bus.out_port   <= arb_sel;
            bus.out_action <= bus.in_action[ACTION_W*arb_sel +: ACTION_W];
            sop_pend       <= 1'b1;
          end
        end
        XFER: begin
          if (xfer) sop_pend <= 1'b0;
          if ((xfer && bus.out_last) || wd_fire) last_grant <= bus.out_port;
        end
      endcase
    end
  end

`ifdef PKT_EGRESS_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;

  // Fires on the TIMEOUT-th consecutive stalled XFER cycle; the pulse lands with the return to IDLE.
  assign wd_fire = (state == XFER) && !xfer && (wd_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt          <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.err_timeout <= wd_fire;
      if ((state != XFER) || xfer || wd_fire) wd_cnt <= '0;
      else                                    wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign wd_fire         = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_egress_arb.sv
// Scoreboard bench for pkt_egress_arb: upstream FIFO models feed ports, expected bytes are queued per packet.
module tb_pkt_egress_arb;
  localparam int NP = 4;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pkt_egress_arb_if #(.NUM_PORTS(NP), .ACTION_W(AW)) bus ();

  pkt_egress_arb #(.NUM_PORTS(NP), .ACTION_W(AW), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]    d;
    logic          l;
    logic [1:0]    p;
    logic [AW-1:0] a;
    logic          s;
  } exp_t;

  exp_t          sb [$];
  logic [8:0]    pq [NP][$];
  logic [AW-1:0] act [NP];
  logic [NP-1:0] stall, stall_arm, xfer_mask;
  logic          rq [$];
  logic          gap_due;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic redrive();
    for (int p = 0; p < NP; p++) begin
      bus.in_valid[p]           = (pq[p].size() != 0) && !stall[p];
      bus.in_data[8*p +: 8]     = 8'h00;
      bus.in_last[p]            = 1'b0;
      if (pq[p].size() != 0) begin
        bus.in_data[8*p +: 8] = pq[p][0][7:0];
        bus.in_last[p]        = pq[p][0][8];
      end
      bus.in_action[AW*p +: AW] = act[p];
    end
  endtask

  task automatic push_exp(input int p, input logic [AW-1:0] a, input logic [7:0] d,
                          input logic l, input logic s);
    exp_t e;
    e.d = d; e.l = l; e.p = 2'(p); e.a = a; e.s = s;
    sb.push_back(e);
  endtask

  // Queue an n-byte packet on port p; the first nsb bytes are expected at egress.
  task automatic load_pkt(input int p, input logic [AW-1:0] a, input int n,
                          input logic [7:0] base, input int nsb);
    act[p] = a;
    for (int i = 0; i < n; i++) begin
      pq[p].push_back({(i == n - 1), 8'(base + i)});
      if (i < nsb) push_exp(p, a, 8'(base + i), (i == n - 1), (i == 0));
    end
    redrive();
  endtask

  task automatic observe();
    exp_t e;
    logic [NP-1:0] er;
    @(negedge clk);
    if (gap_due) begin
      chk("idle_gap_valid", bus.out_valid, 0);
      chk("idle_gap_ready", bus.in_ready, 0);
      gap_due = 1'b0;
    end
    xfer_mask = bus.in_ready & bus.in_valid;
    if (bus.out_valid) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e  = sb[0];
        er = '0;
        if (bus.out_ready) er[e.p] = 1'b1;
        chk("data", bus.out_data, e.d);
        chk("last", bus.out_last, e.l);
        chk("port", bus.out_port, e.p);
        chk("action", bus.out_action, e.a);
        chk("sop", bus.out_sop, e.s);
        chk("in_ready", bus.in_ready, er);
        if (bus.out_ready) begin
          void'(sb.pop_front());
          if (e.l) gap_due = 1'b1;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (xfer_mask[p]) begin
        void'(pq[p].pop_front());
        if (stall_arm[p]) begin
          stall[p]     = 1'b1;
          stall_arm[p] = 1'b0;
        end
      end
    end
    bus.out_ready = 1'b1;
    if (rq.size() != 0) bus.out_ready = rq.pop_front();
    redrive();
  endtask

  task automatic cyc();
    observe();
    advance();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_done", sb.size(), 0);
  endtask

  task automatic do_reset(input logic check_reset);
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      pq[p].delete();
      act[p] = '0;
    end
    sb.delete();
    rq.delete();
    stall = '0; stall_arm = '0; xfer_mask = '0; gap_due = 1'b0;
    bus.out_ready = 1'b1;
    redrive();
    repeat (2) @(posedge clk);
    #3;
    if (check_reset) begin
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_sop", bus.out_sop, 0);
      chk("rst_err", bus.err_timeout, 0);
      chk("rst_out_port", bus.out_port, 0);
      chk("rst_out_action", bus.out_action, 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic seen;
    // Reset state, then a 3-byte packet on port 0
    do_reset(1'b1);
    load_pkt(0, 64'h55, 3, 8'hA1, 3);
    drain(20);
    cyc();

    // All four ports hold 2-byte packets: served 0,1,2,3 with a gap between
    do_reset(1'b0);
    for (int p = 0; p < NP; p++) load_pkt(p, 64'h1000 + 64'(p), 2, 8'(8'h10 * (p + 1)), 2);
    drain(60);
    cyc();

    // Port 1 mid-packet, port 2 arrives, egress backpressure 1,0,1
    do_reset(1'b0);
    load_pkt(1, 64'h11, 3, 8'hC1, 3);
    cyc();
    cyc();
    load_pkt(2, 64'h22, 2, 8'hD1, 2);
    bus.out_ready = 1'b0;
    rq.push_back(1'b1);
    drain(30);
    cyc();

    // Wrap-around: last_grant=2, single-byte packets on ports 3 and 0
    do_reset(1'b0);
    load_pkt(2, 64'h2, 1, 8'hE2, 1);
    drain(10);
    cyc();
    load_pkt(3, 64'h3, 1, 8'hE3, 1);
    load_pkt(0, 64'h0, 1, 8'hE0, 1);
    drain(20);
    cyc();

    // Port 2 stalls after its first byte
    do_reset(1'b0);
    stall_arm[2] = 1'b1;
    load_pkt(2, 64'hC0FFEE, 3, 8'hB1, 1);
    drain(20);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      observe();
      if (bus.err_timeout) seen = 1'b1;
      if (k == 7) chk("wd_hold_pre", bus.in_ready, 4'b0100);
      advance();
    end
    chk("wd_early", seen, 0);
    observe();
`ifdef PKT_EGRESS_ARB_WATCHDOG_EN
    chk("wd_pulse", bus.err_timeout, 1);
    chk("wd_idle", bus.in_ready, 0);
    advance();
    observe();
    chk("wd_pulse_end", bus.err_timeout, 0);
    advance();
    stall[2] = 1'b0;
    redrive();
    push_exp(2, 64'hC0FFEE, 8'hB2, 1'b0, 1'b1);
`else
    chk("wd_off", bus.err_timeout, 0);
    chk("wd_grant_held", bus.in_ready, 4'b0100);
    chk("wd_port", bus.out_port, 2);
    advance();
    stall[2] = 1'b0;
    redrive();
    push_exp(2, 64'hC0FFEE, 8'hB2, 1'b0, 1'b0);
`endif
    push_exp(2, 64'hC0FFEE, 8'hB3, 1'b1, 1'b0);
    drain(20);
    cyc();

    // Asynchronous reset in the middle of a port 1 packet
    do_reset(1'b0);
    load_pkt(1, 64'h77, 3, 8'h71, 1);
    cyc();
    cyc();
    #2;
    chk("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_out_port", bus.out_port, 0);
    chk("arst_out_action", bus.out_action, 0);
    chk("arst_out_sop", bus.out_sop, 0);
    do_reset(1'b0);
    load_pkt(0, 64'h80, 2, 8'h81, 2);
    load_pkt(1, 64'h90, 2, 8'h91, 2);
    drain(30);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
